// File: rtl/fetch_buffer_unit_pkg.sv
// Shared fetch-side definitions: datapath widths, PC stride, FSM encoding and
// the queue entry layout.
package fetch_buffer_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, instruction} pairs; flush clears it in
// one cycle and takes precedence over push/pop.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Guard against misuse so the pointers can never cross each other.
  assign push_ok = push && !flush && (count_q != FULL_CNT);
  assign pop_ok  = pop && !flush && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_buffer_unit.sv
// Instruction fetch front end: one outstanding memory request at a time,
// responses queued for the execute stage, redirects flush and refetch.
module fetch_buffer_unit
  import fetch_buffer_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   FULL_CNT_WIDE = (CNT_W + 1)'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  imem_addr_q, imem_addr_d;

  logic             q_push;
  logic             q_pop;
  logic             q_flush;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     q_push_data;
  logic [CNT_W:0]   count_after;

  assign q_flush     = redirect_valid;
  assign q_pop       = inst_valid && inst_ready && !redirect_valid;
  assign q_push_data = '{pc: imem_addr_q, inst: imem_data};

  // Occupancy as it will be after this cycle's push and pop.
  assign count_after = {1'b0, q_count} + {{CNT_W{1'b0}}, 1'b1}
                     - {{CNT_W{1'b0}}, q_pop};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_addr_d = imem_addr_q;
    q_push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = align_pc(redirect_pc);
        end else if (q_count < FULL_CNT) begin
          state_d     = S_WAIT;
          imem_addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // A same-cycle ack retires the stale request; otherwise drain it.
          fetch_pc_d = align_pc(redirect_pc);
          state_d    = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          q_push     = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_INC;
          if (count_after < FULL_CNT_WIDE) begin
            state_d     = S_WAIT;
            imem_addr_d = fetch_pc_q + PC_INC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect_valid) fetch_pc_d = align_pc(redirect_pc);
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fetch_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .count     (q_count),
    .head      (q_head)
  );

  assign imem_req   = (state_q != S_IDLE);
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (q_count != '0);
  assign inst_out   = inst_valid ? q_head.inst : '0;
  assign inst_pc    = inst_valid ? q_head.pc   : '0;

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Bench for fetch_buffer_unit: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the fetch unit.
module tb_fetch_buffer_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  fetch_buffer_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Model: queued instructions, next fetch address, and the one request in flight.
  ent_t        mq[$];
  logic [31:0] m_fetch_pc;
  logic        m_busy;
  logic        m_discard;
  logic [31:0] m_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch_pc = 32'h0;
    m_busy     = 1'b0;
    m_discard  = 1'b0;
    m_addr     = 32'h0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rp, input logic ack,
                            input logic rdy, input logic [31:0] data);
    int sz0;
    sz0 = mq.size();
    if (rv) begin
      mq.delete();
      m_fetch_pc = {rp[31:2], 2'b00};
      if (m_busy) begin
        if (ack) begin
          m_busy    = 1'b0;
          m_discard = 1'b0;
        end else begin
          m_discard = 1'b1;
        end
      end
    end else begin
      if (sz0 > 0 && rdy) void'(mq.pop_front());
      if (!m_busy) begin
        if (sz0 < DEPTH) begin
          m_busy = 1'b1;
          m_addr = m_fetch_pc;
        end
      end else if (ack) begin
        if (m_discard) begin
          m_busy    = 1'b0;
          m_discard = 1'b0;
        end else begin
          mq.push_back('{pc: m_addr, inst: data});
          m_fetch_pc = m_fetch_pc + 32'd4;
          if (mq.size() < DEPTH) m_addr = m_fetch_pc;
          else m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
    check("imem_addr", imem_addr, m_addr);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, (mq.size() != 0)});
    check("inst_out", inst_out, (mq.size() != 0) ? mq[0].inst : 32'h0);
    check("inst_pc", inst_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
  endtask

  task automatic step(input logic rv, input logic [31:0] rp, input logic ack, input logic rdy);
    @(negedge clock);
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_ack       = ack;
    inst_ready     = rdy;
    imem_data      = mem_word(imem_addr);
    @(posedge clock);
    if (reset) model_reset();
    else model_step(rv, rp, ack, rdy, imem_data);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();

    // Reset values, then first-instruction latency with same-cycle acks.
    do_reset();
    check("rst_addr", imem_addr, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("lat_valid", {31'b0, inst_valid}, 32'h1);
    check("lat_pc", inst_pc, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Stalled consumer: queue fills to DEPTH and fetching stops, then resumes.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("full_req", {31'b0, imem_req}, 32'h0);
    check("full_head", inst_pc, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("resume_addr", imem_addr, 32'h10);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Slow memory: ack three cycles after each request.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end

    // Redirect while waiting; late ack must be dropped.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("drop_empty", {31'b0, inst_valid}, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("drop_refetch", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect, ack and pop together with a full queue.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    check("flush_valid", {31'b0, inst_valid}, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Address wrap at the top of the space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Reset mid-request; ack in the first post-reset cycle is ignored.
    step(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_rst_valid", {31'b0, inst_valid}, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic in phases with varying ack/ready/redirect rates.
    for (int ph = 0; ph < 16; ph++) begin
      int p_ack, p_rdy, p_rv;
      p_ack = $urandom_range(20, 100);
      p_rdy = $urandom_range(0, 100);
      p_rv  = $urandom_range(0, 12);
      for (int i = 0; i < 200; i++) begin
        logic rv, ack, rdy;
        rv  = ($urandom_range(0, 99) < p_rv);
        ack = ($urandom_range(0, 99) < p_ack);
        rdy = ($urandom_range(0, 99) < p_rdy);
        reset = ($urandom_range(0, 499) == 0);
        step(rv, $urandom, ack, rdy);
      end
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
